// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned DAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sw_state_t;

  // Upper value of each display digit before it rolls over.
  localparam int unsigned CS_MAX = 9;
  localparam int unsigned DS_MAX = 9;
  localparam int unsigned S_MAX  = 9;
  localparam int unsigned TS_MAX = 5;

  // Decimal point sits after the seconds digit.
  localparam logic [1:0] PT_SEC = 2'd2;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter, 0..MAX, with synchronous clear and ripple carry.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  // Carry out on the increment that rolls MAX back to zero.
  assign carry = inc && (digit == DIGIT_W'(MAX));

  // Digit register: clear has priority, then roll over, then +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (carry) begin
      digit <= '0;
    end else if (inc) begin
      digit <= digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch (00.00..59.99) feeding a 4-digit 7-segment display.
// Optional lap freeze is compiled in with STOPWATCH_LAP_EN.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_1ms,
  input  logic             btn_ss,
  input  logic             btn_clr,
  input  logic             btn_lap,
  output logic [DAT_W-1:0] dat,
  output logic [1:0]       pt,
  output logic             running,
  output logic             ovf,
  output logic             lap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CS - 1);

  sw_state_t          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_d, ovf_d;
  logic               cs_tick_c, clr_c;
  logic [3:0]         carry;
  logic [DIGIT_W-1:0] d_cs, d_ds, d_s, d_ts;
  logic [DAT_W-1:0]   live;

  // Centisecond tick on the strobe that wraps the prescaler.
  assign cs_tick_c = (state_q == RUN) && ce_1ms && (presc_q == PRESC_LAST);

  // Next-state, prescaler and flag logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_c   = 1'b0;
    ovf_d   = ovf;
    if ((state_q == RUN) && ce_1ms) begin
      presc_d = cs_tick_c ? '0 : presc_q + PRESC_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (btn_ss) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (btn_ss) state_d = STOP;
      end
      STOP: begin
        if (btn_clr) begin
          state_d = IDLE;
          presc_d = '0;
          clr_c   = 1'b1;
        end else if (btn_ss) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_c) begin
      ovf_d = 1'b0;
    end else if (carry[3]) begin
      ovf_d = 1'b1;
    end
    running_d = (state_d == RUN);
  end

  // State, prescaler and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
      pt      <= PT_SEC;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      running <= running_d;
      ovf     <= ovf_d;
      pt      <= PT_SEC;
    end
  end

  bcd_digit_cnt #(.MAX(CS_MAX)) u_cs (
    .clk(clk), .rst(rst), .inc(cs_tick_c), .clr(clr_c), .digit(d_cs), .carry(carry[0])
  );
  bcd_digit_cnt #(.MAX(DS_MAX)) u_ds (
    .clk(clk), .rst(rst), .inc(carry[0]), .clr(clr_c), .digit(d_ds), .carry(carry[1])
  );
  bcd_digit_cnt #(.MAX(S_MAX)) u_s (
    .clk(clk), .rst(rst), .inc(carry[1]), .clr(clr_c), .digit(d_s), .carry(carry[2])
  );
  bcd_digit_cnt #(.MAX(TS_MAX)) u_ts (
    .clk(clk), .rst(rst), .inc(carry[2]), .clr(clr_c), .digit(d_ts), .carry(carry[3])
  );

  assign live = {d_ts, d_s, d_ds, d_cs};

`ifdef STOPWATCH_LAP_EN
  logic [DAT_W-1:0] lap_val;
  logic             lap_d, lap_cap_c;

  // Lap toggles only while running; an effective clear releases it.
  always_comb begin
    lap_d     = lap;
    lap_cap_c = 1'b0;
    if (clr_c) begin
      lap_d = 1'b0;
    end else if ((state_q == RUN) && btn_lap) begin
      lap_d     = ~lap;
      lap_cap_c = ~lap;
    end
  end

  // Lap flag and captured display value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap     <= 1'b0;
      lap_val <= '0;
    end else begin
      lap <= lap_d;
      if (lap_cap_c) lap_val <= live;
    end
  end

  assign dat = lap ? lap_val : live;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap            = 1'b0;
  assign dat            = live;
`endif

endmodule
